// File: rtl/rf_pkg.sv
// Shared definitions for the parametrised register file: FSM state encoding,
// the hardwired-zero address and default geometry shared with the decode and
// hazard units.
package rf_pkg;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

    localparam int RF_ZERO_ADDR  = 0;

    localparam int RF_DATA_W_DEF = 32;
    localparam int RF_DEPTH_DEF  = 32;
    localparam int RF_NUM_RD_DEF = 2;

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer for the register file. After reset or a clear request it
// walks every index once, asking the array to zero it, then reports ready.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RF_INIT | walking clr_addr 0..DEPTH-1, array being zeroed, not ready
// RF_RUN  | array valid, reads and writes allowed
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int DEPTH  = RF_DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              ready,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q,   cnt_d;

    // State and walk index registers; reset restarts the walk from entry 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: walk to the last index, then run until a clear request
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RF_INIT: begin
                if (clr_req) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = RF_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RF_RUN: begin
                if (clr_req) begin
                    state_d = RF_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = RF_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the registered state only
    always_comb begin
        ready    = (state_q == RF_RUN);
        clr_we   = (state_q == RF_INIT);
        clr_addr = cnt_q;
    end

endmodule

// File: rtl/param_reg_file.sv
// Parametrised register file: DATA_W x DEPTH, NUM_RD combinational read ports,
// one synchronous write port, hardwired-zero entry 0 and a hardware clear
// sequence after reset or on clr_req.
// Optional feature macro: PARAM_RF_BYPASS_EN (same-cycle write-through
// forwarding to read lanes while running).
module param_reg_file
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W_DEF,
    parameter int DEPTH  = RF_DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_RD = RF_NUM_RD_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     ready,
    output logic [ADDR_W-1:0]        clr_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;

    rf_clear_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign clr_cnt = clr_addr;

    // A caller write lands only while running, never on entry 0, and is
    // dropped when it coincides with a clear request.
    assign wr_ok = ready && wr_en && !clr_req && (wr_addr != ZERO_ADDR);

    // Array update: the clear walk owns the array in INIT, caller writes in RUN
    always_comb begin
        mem_d = mem_q;
        if (rst_n) begin
            if (clr_we) begin
                mem_d[clr_addr] = '0;
            end else if (wr_ok) begin
                mem_d[wr_addr] = wr_data;
            end
        end
    end

    // Storage has no reset; the clear walk is what makes it valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];

        // Read lane: zero while clearing or for entry 0, else stored value
        always_comb begin
            data = '0;
            if (ready && (addr != ZERO_ADDR)) begin
                data = mem_q[addr];
            end
`ifdef PARAM_RF_BYPASS_EN
            if (ready && wr_en && (wr_addr != ZERO_ADDR) && (addr == wr_addr)) begin
                data = wr_data;
            end
`endif
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
    end

endmodule

// File: tb/tb_param_reg_file.sv
// Self-checking bench for param_reg_file: a default 32x32x2 instance and a
// 16x8x3 instance, each compared every cycle against a reference model.
module tb_param_reg_file;

    localparam int AW = 5,  DW = 32, NR = 2, DP = 32;
    localparam int BAW = 3, BDW = 16, BNR = 3, BDP = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n_a   = 1'b0;
    logic                clr_req_a = 1'b0;
    logic [NR*AW-1:0]    rd_addr_a = '0;
    logic [NR*DW-1:0]    rd_data_a;
    logic                wr_en_a   = 1'b0;
    logic [AW-1:0]       wr_addr_a = '0;
    logic [DW-1:0]       wr_data_a = '0;
    logic                ready_a;
    logic [AW-1:0]       clr_cnt_a;

    logic                rst_n_b   = 1'b0;
    logic                clr_req_b = 1'b0;
    logic [BNR*BAW-1:0]  rd_addr_b = '0;
    logic [BNR*BDW-1:0]  rd_data_b;
    logic                wr_en_b   = 1'b0;
    logic [BAW-1:0]      wr_addr_b = '0;
    logic [BDW-1:0]      wr_data_b = '0;
    logic                ready_b;
    logic [BAW-1:0]      clr_cnt_b;

    param_reg_file u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .clr_req(clr_req_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .ready(ready_a), .clr_cnt(clr_cnt_a)
    );

    param_reg_file #(.DATA_W(BDW), .DEPTH(BDP), .NUM_RD(BNR)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .clr_req(clr_req_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .ready(ready_b), .clr_cnt(clr_cnt_b)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: array contents plus cycles of clearing still to go
    logic [DW-1:0]  ref_a [DP];
    int             left_a  = DP;
    bit             known_a = 1'b0;
    logic [BDW-1:0] ref_b [BDP];
    int             left_b  = BDP;
    bit             known_b = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle_a(input bit rst, input bit clr, input bit we, input int wa,
                           input logic [DW-1:0] wd, input int ra0, input int ra1);
        int ra [NR];
        logic [DW-1:0] exp;
        ra[0] = ra0;
        ra[1] = ra1;
        rst_n_a   = !rst;
        clr_req_a = clr;
        wr_en_a   = we;
        wr_addr_a = AW'(wa);
        wr_data_a = wd;
        rd_addr_a = {AW'(ra1), AW'(ra0)};
        @(negedge clk);
        if (known_a) begin
            chk("a_ready", 64'(ready_a), 64'(left_a == 0));
            chk("a_clr_cnt", 64'(clr_cnt_a), 64'(left_a == 0 ? 0 : DP - left_a));
            for (int k = 0; k < NR; k++) begin
                exp = '0;
                if (left_a == 0 && ra[k] != 0) exp = ref_a[ra[k]];
`ifdef PARAM_RF_BYPASS_EN
                if (left_a == 0 && we && wa != 0 && ra[k] == wa) exp = wd;
`endif
                chk($sformatf("a_rd%0d[%0d]", k, ra[k]), 64'(rd_data_a[k*DW +: DW]), 64'(exp));
            end
        end
        if (rst) begin
            for (int i = 0; i < DP; i++) ref_a[i] = '0;
            left_a  = DP;
            known_a = 1'b1;
        end else if (left_a > 0) begin
            left_a = clr ? DP : left_a - 1;
        end else if (clr) begin
            for (int i = 0; i < DP; i++) ref_a[i] = '0;
            left_a = DP;
        end else if (we && wa != 0) begin
            ref_a[wa] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_b(input bit rst, input bit clr, input bit we, input int wa,
                           input logic [BDW-1:0] wd, input int ra0, input int ra1, input int ra2);
        int ra [BNR];
        logic [BDW-1:0] exp;
        ra[0] = ra0;
        ra[1] = ra1;
        ra[2] = ra2;
        rst_n_b   = !rst;
        clr_req_b = clr;
        wr_en_b   = we;
        wr_addr_b = BAW'(wa);
        wr_data_b = wd;
        rd_addr_b = {BAW'(ra2), BAW'(ra1), BAW'(ra0)};
        @(negedge clk);
        if (known_b) begin
            chk("b_ready", 64'(ready_b), 64'(left_b == 0));
            chk("b_clr_cnt", 64'(clr_cnt_b), 64'(left_b == 0 ? 0 : BDP - left_b));
            for (int k = 0; k < BNR; k++) begin
                exp = '0;
                if (left_b == 0 && ra[k] != 0) exp = ref_b[ra[k]];
`ifdef PARAM_RF_BYPASS_EN
                if (left_b == 0 && we && wa != 0 && ra[k] == wa) exp = wd;
`endif
                chk($sformatf("b_rd%0d[%0d]", k, ra[k]), 64'(rd_data_b[k*BDW +: BDW]), 64'(exp));
            end
        end
        if (rst) begin
            for (int i = 0; i < BDP; i++) ref_b[i] = '0;
            left_b  = BDP;
            known_b = 1'b1;
        end else if (left_b > 0) begin
            left_b = clr ? BDP : left_b - 1;
        end else if (clr) begin
            for (int i = 0; i < BDP; i++) ref_b[i] = '0;
            left_b = BDP;
        end else if (we && wa != 0) begin
            ref_b[wa] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic read_all_a();
        for (int i = 0; i < DP; i += 2) cycle_a(0, 0, 0, 0, '0, i, i + 1);
    endtask

    initial begin
        int n;

        // Reset, then count the clear time; a write at cycle 10 must be dropped
        cycle_a(1, 0, 0, 0, '0, 0, 0);
        cycle_a(1, 0, 0, 0, '0, 0, 0);
        n = 0;
        while (ready_a !== 1'b1 && n < 100) begin
            cycle_a(0, 0, (n == 10), 3, 32'hCAFE_F00D,
                    int'($urandom_range(0, DP - 1)), int'($urandom_range(0, DP - 1)));
            n++;
        end
        chk("a_init_len", 64'(n), 64'(DP));
        read_all_a();

        // Basic write/read on both lanes
        cycle_a(0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0);
        cycle_a(0, 0, 0, 0, '0, 5, 5);

        // Write to entry 0 is discarded
        cycle_a(0, 0, 1, 0, 32'h1234_5678, 0, 5);
        cycle_a(0, 0, 0, 0, '0, 0, 0);
        read_all_a();

        // Same-cycle read of the entry being written
        cycle_a(0, 0, 1, 9, 32'h1, 0, 0);
        cycle_a(0, 0, 1, 9, 32'h2, 9, 9);
        cycle_a(0, 0, 0, 0, '0, 9, 9);

        // Clear request with a coincident write, then re-count the clear time
        cycle_a(0, 0, 1, 7, 32'hA5A5_A5A5, 7, 0);
        cycle_a(0, 0, 0, 0, '0, 7, 7);
        cycle_a(0, 1, 1, 7, 32'h1111_1111, 7, 7);
        n = 0;
        while (ready_a !== 1'b1 && n < 100) begin
            cycle_a(0, 0, 0, 0, '0, 7, 9);
            n++;
        end
        chk("a_clr_len", 64'(n), 64'(DP));
        cycle_a(0, 0, 0, 0, '0, 7, 5);

        // Restart mid-walk by clear request and by reset
        cycle_a(0, 1, 0, 0, '0, 0, 0);
        for (int i = 0; i < 5; i++) cycle_a(0, 0, 0, 0, '0, 1, 2);
        cycle_a(0, 1, 0, 0, '0, 0, 0);
        for (int i = 0; i < 5; i++) cycle_a(0, 0, 0, 0, '0, 1, 2);
        cycle_a(1, 0, 0, 0, '0, 0, 0);

        // Randomised traffic including occasional clears and resets
        for (int i = 0; i < 600; i++) begin
            cycle_a(($urandom % 250) == 0, ($urandom % 60) == 0, $urandom % 2,
                    int'($urandom_range(0, DP - 1)), $urandom,
                    int'($urandom_range(0, DP - 1)), int'($urandom_range(0, DP - 1)));
        end
        for (int i = 0; i < 2 * DP + 2; i++) cycle_a(0, 0, 0, 0, '0, 0, 0);
        read_all_a();

        // Second geometry: 16-bit x 8 entries, three read lanes
        cycle_b(1, 0, 0, 0, '0, 0, 0, 0);
        n = 0;
        while (ready_b !== 1'b1 && n < 100) begin
            cycle_b(0, 0, 0, 0, '0, n % BDP, (n + 3) % BDP, (n + 5) % BDP);
            n++;
        end
        chk("b_init_len", 64'(n), 64'(BDP));
        cycle_b(0, 0, 1, 7, 16'hBEEF, 0, 0, 0);
        cycle_b(0, 0, 1, 0, 16'h1234, 7, 0, 7);
        cycle_b(0, 0, 1, 3, 16'h0F0F, 7, 0, 1);
        cycle_b(0, 0, 0, 0, '0, 3, 7, 0);
        for (int i = 0; i < 300; i++) begin
            cycle_b(($urandom % 200) == 0, ($urandom % 40) == 0, $urandom % 2,
                    int'($urandom_range(0, BDP - 1)), 16'($urandom),
                    int'($urandom_range(0, BDP - 1)), int'($urandom_range(0, BDP - 1)),
                    int'($urandom_range(0, BDP - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/param_reg_file.md
Name: param_reg_file

Overview:
- Parametrised successor to the CPU's 32x32 register file: configurable data width, depth and number of combinational read ports, plus one synchronous write port.
- Adds a hardwired-zero entry 0 and a hardware clear sequencer that zeroes every entry after reset or on request, so no stale X reaches the datapath.
- Sits in the decode stage. The pipeline controller stalls issue until `ready` is high.

Parameters:
- DATA_W, 32, bits per register
- DEPTH, 32, number of registers; power of two, ≥2
- ADDR_W, $clog2(DEPTH), address width; derived, do not override
- NUM_RD, 2, number of read ports, 1..4

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- clr_req  in  1  one-cycle pulse: re-run the clear sequence
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, same packing as rd_addr
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- ready  out  1  high when the array is valid and accepting writes
- clr_cnt  out  ADDR_W  current clear index (debug/observability)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low: sampled only at the rising edge of clk while rst_n=0.
- FSM states: INIT, RUN.
- Reset (rst_n=0 at a rising edge):
  - state←INIT, clr_cnt←0, ready←0.
  - Array contents are not touched by reset itself; the INIT walk clears them.
- INIT:
  - Each cycle, R[clr_cnt]←0 and clr_cnt←clr_cnt+1.
  - When clr_cnt==DEPTH-1 is written, move to RUN next cycle and set clr_cnt←0.
  - Total clear time is DEPTH cycles from reset release to ready=1.
  - wr_en is ignored in INIT and the write is dropped. The caller must hold writes until ready=1.
  - All rd_data lanes read 0 while in INIT.
  - clr_req in INIT restarts the walk: clr_cnt←0.
- RUN:
  - ready=1.
  - Write: at a posedge with wr_en=1 and wr_addr≠0, R[wr_addr]←wr_data.
  - A write to address 0 is discarded. R[0] always reads 0.
  - Read: rd_data[k]=R[rd_addr[k]], combinational, zero-latency.
  - Reading the address being written in the same cycle returns the old value (write-first only via the optional feature).
  - clr_req=1: move to INIT next cycle, clr_cnt←0, ready←0. A write presented in the same cycle as clr_req is dropped.
- Priority, highest first: rst_n=0, then clr_req, then wr_en.
- Widths:
  - Addresses are always in range, since DEPTH is a power of two.
  - No arithmetic on data; clr_cnt wraps naturally at DEPTH.
- Reset mid-INIT restarts at 0. Reset mid-RUN forces INIT.

Optional Feature:
- Macro: PARAM_RF_BYPASS_EN.
- Defined:
  - In RUN, if wr_en=1, wr_addr≠0 and rd_addr[k]==wr_addr, then rd_data[k]=wr_data in the same cycle (write-through forwarding).
  - This lets the decode stage skip a writeback hazard stall.
- Undefined: reads return the stored value; the new data is visible the cycle after the write.
- Bypass never applies in INIT or to address 0.

Decomposition:
- Shared package `rf_pkg`:
  - FSM state enum {RF_INIT, RF_RUN}
  - localparam RF_ZERO_ADDR=0
  - Defaults for DATA_W, DEPTH and NUM_RD, shared with the decode and hazard units.
- Sub-module `rf_clear_seq`: the INIT/RUN FSM plus clr_cnt counter. Outputs ready, clr_we and clr_addr to the array.
- The array and read muxes (generate loop over NUM_RD) stay in the top module.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then release.
  - ready=0 for exactly 32 cycles, then 1.
  - All 32 entries read 0; rd_data is 0 throughout INIT.
- Basic write/read: write 0xDEADBEEF to R5, then set rd_addr0=5 and rd_addr1=5 next cycle.
  - Both lanes read 0xDEADBEEF.
- Zero register: write 0x12345678 to R0.
  - R0 still reads 0; R1..R31 unchanged.
- Write during INIT and clr_req:
  - wr_en at cycle 10 after reset: dropped, R[addr] reads 0 after ready=1.
  - In RUN, write R7=0xA5A5A5A5, then pulse clr_req: ready drops for 32 cycles and R7 reads 0 afterwards.
- Same-cycle read/write of R9 (old value 0x1, new 0x2):
  - Without PARAM_RF_BYPASS_EN, rd_data=0x1 in that cycle and 0x2 the next.
  - With PARAM_RF_BYPASS_EN, rd_data=0x2 in the same cycle.
- Parameter sweep: DATA_W=16, DEPTH=8, NUM_RD=3.
  - Init takes 8 cycles.
  - Three independent read lanes return the correct values.
  - Write to R7 then a write to R0 behave as above.
